stb_datapath: RTL and testbench
===============================

Name: stb_datapath

Overview:
- Storage and pointer datapath of the store buffer. Driven by the store-buffer controller's write, read and initial-read strobes; returns full/empty status to it.
- Captures LSU stores into a circular FIFO and presents the oldest entry to the data cache as a write request.
- Provides a store-to-load forwarding lookup so younger loads observe buffered stores.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, ≥2
- ADDR_W, 32, byte address width
- DATA_W, 32, store data width; byte-select width is DATA_W/8

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stb_wr_en  in  1  controller: push LSU store this cycle
- stb_r_en  in  1  controller: head entry committed to cache, pop it
- stb_initial_read  in  1  controller: launch cache write of head while no request is in flight
- lsudbus2stb_addr  in  ADDR_W  store address
- lsudbus2stb_wdata  in  DATA_W  store data
- lsudbus2stb_sel  in  DATA_W/8  store byte enables
- cache_write_ack  in  1  cache: head write accepted
- ld_lookup_addr  in  ADDR_W  load address for forwarding
- stb_full  out  1  count == DEPTH
- stb_empty  out  1  count == 0
- stb2dcache_req  out  1  write request to cache (registered)
- stb2dcache_w_en  out  1  equals stb2dcache_req
- stb2dcache_addr  out  ADDR_W  head entry address
- stb2dcache_wdata  out  DATA_W  head entry data
- stb2dcache_sel  out  DATA_W/8  head entry byte enables
- fwd_hit  out  1  a valid entry matches the load word address
- fwd_data  out  DATA_W  data of youngest matching entry
- fwd_sel  out  DATA_W/8  byte enables of youngest matching entry

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, count=0, all valid bits=0, stb2dcache_req=0. Outputs: stb_empty=1, stb_full=0, fwd_hit=0; all data outputs 0. Reset mid-operation discards all entries and any in-flight request.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Push: stb_wr_en && (!stb_full || pop). Writes {addr, wdata, sel} at wr_ptr, sets valid, wr_ptr+1. Push while full without pop is dropped; state unchanged.
- Pop: stb_r_en && !stb_empty. Clears valid[rd_ptr], rd_ptr+1. Pop on empty is ignored.
- Count update: count + push - pop. Simultaneous push and pop leaves count unchanged.
- stb_full and stb_empty are combinational from registered count; push/pop take effect on the next cycle.
- Cache outputs: stb2dcache_addr/wdata/sel are combinational from entry[rd_ptr]. They are 0 when empty.
- stb2dcache_req next-state, in priority order:
  - pop: req <= (count - 1 + push) != 0.
  - else cache_write_ack: req <= 0.
  - else stb_initial_read: req <= 1. A push into an empty buffer with initial_read asserts req one cycle later, with the new entry at the head.
  - else hold.
- Request latency: store pushed at cycle N into an empty buffer with initial_read → req=1 at N+1 → pop at the ack cycle → next head requested the following cycle if any entry remains.
- Head stability: the head entry never changes while req=1 except through pop.
- Forwarding (combinational):
  - Match = valid[i] && entry[i].addr[ADDR_W-1:2] == ld_lookup_addr[ADDR_W-1:2].
  - Youngest match is searched from wr_ptr-1 backward to rd_ptr, with wrap.
  - fwd_hit=1 on any match; fwd_data/fwd_sel come from the youngest match. With no match, fwd_hit=0 and fwd_data/fwd_sel=0.
  - The entry being pushed this cycle is not visible. The entry being popped this cycle is still visible.

Test Plan:
- Reset then idle → stb_empty=1, stb_full=0, req=0. Pop with stb_r_en=1 on empty → count stays 0, rd_ptr=0.
- Push addr 0x100, data 0xDEADBEEF, sel 0xF with initial_read → next cycle req=1, addr=0x100, wdata=0xDEADBEEF. Ack with r_en → stb_empty=1, req=0 next cycle.
- Four pushes (0x10,0x14,0x18,0x1C) → stb_full=1. Fifth push 0x20 without pop → dropped. Drain with 4 ack+r_en → heads appear in order 0x10,0x14,0x18,0x1C; req stays 1 until the last pop.
- Full plus simultaneous push 0x20 and pop → count stays 4, stb_full=1, new tail=0x20. After six pops/pushes, wrap-around order is preserved.
- Push 0x40/0x11111111/sel 0x3, then 0x40/0x22222222/sel 0xC. Lookup 0x42 → fwd_hit=1, fwd_data=0x22222222, fwd_sel=0xC. Lookup 0x44 → fwd_hit=0.
- Assert rst_n=0 with 3 entries and req=1 → asynchronously stb_empty=1, req=0, fwd_hit=0. After release, the first push lands at index 0.

Source files
------------

// File: rtl/stb_datapath.sv
// Store buffer storage and pointer datapath: circular FIFO of LSU stores,
// head-of-queue cache write request, and store-to-load forwarding lookup.
module stb_datapath #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stb_wr_en,
  input  logic                stb_r_en,
  input  logic                stb_initial_read,
  input  logic [ADDR_W-1:0]   lsudbus2stb_addr,
  input  logic [DATA_W-1:0]   lsudbus2stb_wdata,
  input  logic [DATA_W/8-1:0] lsudbus2stb_sel,
  input  logic                cache_write_ack,
  input  logic [ADDR_W-1:0]   ld_lookup_addr,
  output logic                stb_full,
  output logic                stb_empty,
  output logic                stb2dcache_req,
  output logic                stb2dcache_w_en,
  output logic [ADDR_W-1:0]   stb2dcache_addr,
  output logic [DATA_W-1:0]   stb2dcache_wdata,
  output logic [DATA_W/8-1:0] stb2dcache_sel,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data,
  output logic [DATA_W/8-1:0] fwd_sel
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SEL_W = DATA_W / 8;

  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];
  logic [SEL_W-1:0]  r_sel   [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic              r_req;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W:0]    w_nextCount;
  logic              w_nextReq;
  logic [PTR_W-1:0]  w_idx;
  logic              w_fwdHit;
  logic [DATA_W-1:0] w_fwdData;
  logic [SEL_W-1:0]  w_fwdSel;

  assign w_full      = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = stb_r_en && !w_empty;
  // A full buffer still accepts a push when the head is popped in the same cycle.
  assign w_push      = stb_wr_en && (!w_full || w_pop);
  assign w_nextCount = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wrPtr]  <= lsudbus2stb_addr;
      r_wdata[r_wrPtr] <= lsudbus2stb_wdata;
      r_sel[r_wrPtr]   <= lsudbus2stb_sel;
    end
  end

  // When full, push and pop hit the same slot; the later set must win over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
      r_count <= w_nextCount;
    end
  end

  always_comb begin
    w_nextReq = r_req;
    if (w_pop) begin
      w_nextReq = (w_nextCount != '0);
    end else if (cache_write_ack) begin
      w_nextReq = 1'b0;
    end else if (stb_initial_read) begin
      w_nextReq = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else begin
      r_req <= w_nextReq;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    w_idx     = '0;
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    w_fwdSel  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rdPtr + PTR_W'(k);
      if (r_valid[w_idx] && (r_addr[w_idx][ADDR_W-1:2] == ld_lookup_addr[ADDR_W-1:2])) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_wdata[w_idx];
        w_fwdSel  = r_sel[w_idx];
      end
    end
  end

  assign stb_full         = w_full;
  assign stb_empty        = w_empty;
  assign stb2dcache_req   = r_req;
  assign stb2dcache_w_en  = r_req;
  assign stb2dcache_addr  = w_empty ? '0 : r_addr[r_rdPtr];
  assign stb2dcache_wdata = w_empty ? '0 : r_wdata[r_rdPtr];
  assign stb2dcache_sel   = w_empty ? '0 : r_sel[r_rdPtr];
  assign fwd_hit          = w_fwdHit;
  assign fwd_data         = w_fwdData;
  assign fwd_sel          = w_fwdSel;

endmodule

// File: tb/tb_stb_datapath.sv
// Self-checking bench for stb_datapath: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_stb_datapath;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb_wr_en = 1'b0;
  logic        stb_r_en = 1'b0;
  logic        stb_initial_read = 1'b0;
  logic [31:0] lsudbus2stb_addr = '0;
  logic [31:0] lsudbus2stb_wdata = '0;
  logic [3:0]  lsudbus2stb_sel = '0;
  logic        cache_write_ack = 1'b0;
  logic [31:0] ld_lookup_addr = '0;
  logic        stb_full, stb_empty, stb2dcache_req, stb2dcache_w_en;
  logic [31:0] stb2dcache_addr, stb2dcache_wdata;
  logic [3:0]  stb2dcache_sel;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_sel;

  int checks = 0;
  int errors = 0;
  bit cmpEn = 1'b0;

  ent_t mq[$];
  bit   mReq = 1'b0;

  stb_datapath #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .stb_wr_en(stb_wr_en), .stb_r_en(stb_r_en), .stb_initial_read(stb_initial_read),
    .lsudbus2stb_addr(lsudbus2stb_addr), .lsudbus2stb_wdata(lsudbus2stb_wdata),
    .lsudbus2stb_sel(lsudbus2stb_sel), .cache_write_ack(cache_write_ack),
    .ld_lookup_addr(ld_lookup_addr),
    .stb_full(stb_full), .stb_empty(stb_empty),
    .stb2dcache_req(stb2dcache_req), .stb2dcache_w_en(stb2dcache_w_en),
    .stb2dcache_addr(stb2dcache_addr), .stb2dcache_wdata(stb2dcache_wdata),
    .stb2dcache_sel(stb2dcache_sel),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_sel(fwd_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, request flag from the priority rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mReq = 1'b0;
    end else begin
      bit pop, push;
      pop  = stb_r_en && (mq.size() > 0);
      push = stb_wr_en && ((mq.size() < DEPTH) || pop);
      if (pop)                   mReq = ((mq.size() - 1 + int'(push)) != 0);
      else if (cache_write_ack)  mReq = 1'b0;
      else if (stb_initial_read) mReq = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({lsudbus2stb_addr, lsudbus2stb_wdata, lsudbus2stb_sel});
    end
  end

  task automatic checkOutput();
    ent_t head;
    bit   hit;
    ent_t fwd;
    head = '0;
    hit  = 1'b0;
    fwd  = '0;
    if (mq.size() > 0) head = mq[0];
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && (mq[i].a[31:2] == ld_lookup_addr[31:2])) begin
        hit = 1'b1;
        fwd = mq[i];
      end
    end
    chk("full",  stb_full,         64'(mq.size() == DEPTH));
    chk("empty", stb_empty,        64'(mq.size() == 0));
    chk("req",   stb2dcache_req,   64'(mReq));
    chk("w_en",  stb2dcache_w_en,  64'(mReq));
    chk("addr",  stb2dcache_addr,  64'(head.a));
    chk("wdata", stb2dcache_wdata, 64'(head.d));
    chk("sel",   stb2dcache_sel,   64'(head.s));
    chk("fwd_hit",  fwd_hit,  64'(hit));
    chk("fwd_data", fwd_data, 64'(fwd.d));
    chk("fwd_sel",  fwd_sel,  64'(fwd.s));
  endtask

  always @(negedge clk) begin
    if (cmpEn) checkOutput();
  end

  // Drive one cycle of inputs (called at posedge+1), return at the next posedge+1.
  task automatic applyStimulus(input bit wr, input bit rd, input bit init, input bit ack,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    stb_wr_en        = wr;
    stb_r_en         = rd;
    stb_initial_read = init;
    cache_write_ack  = ack;
    lsudbus2stb_addr  = a;
    lsudbus2stb_wdata = d;
    lsudbus2stb_sel   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmpEn = 1'b1;
    chk("rst_empty", stb_empty, 1);
    chk("rst_full", stb_full, 0);
    chk("rst_req", stb2dcache_req, 0);
    chk("rst_fwd_hit", fwd_hit, 0);

    applyStimulus(0, 1, 0, 0, '0, '0, '0);
    chk("pop_empty", stb_empty, 1);

    applyStimulus(1, 0, 1, 0, 32'h100, 32'hDEADBEEF, 4'hF);
    chk("single_req", stb2dcache_req, 1);
    chk("single_addr", stb2dcache_addr, 32'h100);
    chk("single_wdata", stb2dcache_wdata, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 1, '0, '0, '0);
    chk("single_drain_empty", stb_empty, 1);
    chk("single_drain_req", stb2dcache_req, 0);

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 0, 0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    chk("fill_full", stb_full, 1);
    applyStimulus(1, 0, 0, 0, 32'h20, 32'hBAD, 4'hF);
    chk("drop_full", stb_full, 1);
    chk("drop_head", stb2dcache_addr, 32'h10);
    applyStimulus(0, 0, 1, 0, '0, '0, '0);
    chk("drain_req0", stb2dcache_req, 1);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(0, 1, 0, 1, '0, '0, '0);
      chk("drain_head", stb2dcache_addr, 32'h10 + 32'(4 * i));
      chk("drain_req", stb2dcache_req, 1);
    end
    applyStimulus(0, 1, 0, 1, '0, '0, '0);
    chk("drain_last_empty", stb_empty, 1);
    chk("drain_last_req", stb2dcache_req, 0);

    applyStimulus(1, 0, 1, 0, 32'h10, 32'hA0, 4'hF);
    for (int i = 1; i < 4; i++)
      applyStimulus(1, 0, 0, 0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    applyStimulus(1, 1, 0, 1, 32'h20, 32'hA4, 4'hF);
    chk("pp_full", stb_full, 1);
    chk("pp_head", stb2dcache_addr, 32'h14);
    for (int i = 1; i < 6; i++)
      applyStimulus(1, 1, 0, 1, 32'h20 + 32'(4 * i), 32'hA4 + 32'(i), 4'hF);
    chk("wrap_head", stb2dcache_addr, 32'h28);
    chk("wrap_full", stb_full, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1, '0, '0, '0);
    chk("wrap_empty", stb_empty, 1);

    applyStimulus(1, 0, 0, 0, 32'h40, 32'h11111111, 4'h3);
    applyStimulus(1, 0, 0, 0, 32'h40, 32'h22222222, 4'hC);
    stb_wr_en = 1'b0;
    ld_lookup_addr = 32'h42;
    #1;
    chk("fwd_young_hit", fwd_hit, 1);
    chk("fwd_young_data", fwd_data, 32'h22222222);
    chk("fwd_young_sel", fwd_sel, 4'hC);
    ld_lookup_addr = 32'h44;
    #1;
    chk("fwd_miss", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    ld_lookup_addr = 32'h40;
    applyStimulus(1, 0, 1, 0, 32'h80, 32'h33333333, 4'hF);
    chk("prerst_req", stb2dcache_req, 1);
    chk("prerst_hit", fwd_hit, 1);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_empty", stb_empty, 1);
    chk("async_req", stb2dcache_req, 0);
    chk("async_hit", fwd_hit, 0);
    chk("async_addr", stb2dcache_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 1, 0, 32'h200, 32'h44444444, 4'h5);
    chk("postrst_head", stb2dcache_addr, 32'h200);
    chk("postrst_req", stb2dcache_req, 1);
    idle();

    for (int n = 0; n < 600; n++) begin
      ld_lookup_addr = {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)};
      applyStimulus(bit'($urandom_range(0, 99) < 55), bit'($urandom_range(0, 99) < 40),
                    bit'($urandom_range(0, 99) < 30), bit'($urandom_range(0, 99) < 20),
                    {27'h0, 3'($urandom_range(0, 7)), 2'($urandom)}, $urandom, 4'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end
    idle();
    cmpEn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
